// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush/redirect control for the 5-stage core.
// Vector bit map: 0 = pc, 1 = if_id, 2 = id_ex, 3 = ex_mem, 4 = mem_wb, 5 = wb (always 0).
// A trap drains any outstanding data-bus transaction before the PC is vectored.
// Optional build macro: PIPE_CTRL_PERF_EN enables the stall/redirect perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned CTRL_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_use_req_i,
    input  logic              if_busy_i,
    input  logic              ex_busy_i,
    input  logic              mem_busy_i,
    input  logic              branch_req_i,
    input  logic [XLEN-1:0]   branch_pc_i,
    input  logic              trap_req_i,
    input  logic [XLEN-1:0]   trap_pc_i,
    input  logic              perf_clr_i,
    output logic [CTRL_W-1:0] stall_valid_o,
    output logic [CTRL_W-1:0] flush_valid_o,
    output logic              redirect_valid_o,
    output logic [XLEN-1:0]   redirect_pc_o,
    output logic              branch_ack_o,
    output logic              trap_ack_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       redirect_cnt_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrain = 2'd1,
        StRedir = 2'd2
    } state_e;

    // Per-stage masks (bit 5 is never set by any of them).
    localparam logic [CTRL_W-1:0] MaskNone   = CTRL_W'(6'h00);
    localparam logic [CTRL_W-1:0] MaskPc     = CTRL_W'(6'h01);
    localparam logic [CTRL_W-1:0] MaskIfId   = CTRL_W'(6'h02);
    localparam logic [CTRL_W-1:0] MaskUpToIf = CTRL_W'(6'h03);
    localparam logic [CTRL_W-1:0] MaskIdEx   = CTRL_W'(6'h04);
    localparam logic [CTRL_W-1:0] MaskIfIdEx = CTRL_W'(6'h06);
    localparam logic [CTRL_W-1:0] MaskUpToId = CTRL_W'(6'h07);
    localparam logic [CTRL_W-1:0] MaskExMem  = CTRL_W'(6'h08);
    localparam logic [CTRL_W-1:0] MaskUpToEx = CTRL_W'(6'h0F);
    localparam logic [CTRL_W-1:0] MaskMemWb  = CTRL_W'(6'h10);
    localparam logic [CTRL_W-1:0] MaskAllPipe = CTRL_W'(6'h1E);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   trap_pc_q, trap_pc_d;

    logic [CTRL_W-1:0] stall_c, flush_c;
    logic              redir_c, back_c, tack_c;
    logic [XLEN-1:0]   redir_pc_c;

    // Control state: FSM state and the latched trap target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            trap_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            trap_pc_q <= trap_pc_d;
        end
    end

    // Next-state and hazard decode; first matching request wins in IDLE.
    always_comb begin
        state_d    = state_q;
        trap_pc_d  = trap_pc_q;
        stall_c    = MaskNone;
        flush_c    = MaskNone;
        redir_c    = 1'b0;
        redir_pc_c = '0;
        back_c     = 1'b0;
        tack_c     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trap_req_i) begin
                    tack_c    = 1'b1;
                    trap_pc_d = trap_pc_i;
                    stall_c   = MaskPc;
                    flush_c   = MaskAllPipe;
                    state_d   = mem_busy_i ? StDrain : StRedir;
                end else if (mem_busy_i) begin
                    stall_c = MaskUpToEx;
                    flush_c = MaskMemWb;
                end else if (ex_busy_i) begin
                    // Branch is held off until EX frees up.
                    stall_c = MaskUpToId;
                    flush_c = MaskExMem;
                end else if (branch_req_i) begin
                    back_c     = 1'b1;
                    redir_c    = 1'b1;
                    redir_pc_c = branch_pc_i;
                    flush_c    = MaskIfIdEx;
                end else if (load_use_req_i) begin
                    stall_c = MaskUpToIf;
                    flush_c = MaskIdEx;
                end else if (if_busy_i) begin
                    stall_c = MaskPc;
                    flush_c = MaskIfId;
                end
            end
            StDrain: begin
                stall_c = MaskPc;
                flush_c = MaskAllPipe;
                if (!mem_busy_i) begin
                    state_d = StRedir;
                end
            end
            StRedir: begin
                redir_c    = 1'b1;
                redir_pc_c = trap_pc_q;
                flush_c    = MaskAllPipe;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are held at 0 for the whole time reset is asserted.
    always_comb begin
        stall_valid_o    = rst ? stall_c : MaskNone;
        flush_valid_o    = rst ? flush_c : MaskNone;
        redirect_valid_o = rst & redir_c;
        redirect_pc_o    = rst ? redir_pc_c : '0;
        branch_ack_o     = rst & back_c;
        trap_ack_o       = rst & tack_c;
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, redirect_cnt_q;

    // Perf counters: clear beats increment, both wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else if (perf_clr_i) begin
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (stall_c[0]) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redir_c) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
        end
    end

    // Counter outputs also read 0 while reset is held.
    always_comb begin
        stall_cnt_o    = rst ? stall_cnt_q : 32'd0;
        redirect_cnt_o = rst ? redirect_cnt_q : 32'd0;
    end
`else
    logic unused_perf_clr;

    // Counters not built; clear input has no effect.
    always_comb begin
        stall_cnt_o     = 32'd0;
        redirect_cnt_o  = 32'd0;
        unused_perf_clr = perf_clr_i;
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed-vector bench for pipe_hazard_ctrl.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
module tb_pipe_hazard_ctrl;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned CTRL_W = 6;

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [31:0] ExpStallCnt = 32'd5;
    localparam logic [31:0] ExpRedirCnt = 32'd2;
`else
    localparam logic [31:0] ExpStallCnt = 32'd0;
    localparam logic [31:0] ExpRedirCnt = 32'd0;
`endif

    logic              clk;
    logic              rst;
    logic              load_use_req;
    logic              if_busy;
    logic              ex_busy;
    logic              mem_busy;
    logic              branch_req;
    logic [XLEN-1:0]   branch_pc;
    logic              trap_req;
    logic [XLEN-1:0]   trap_pc;
    logic              perf_clr;
    logic [CTRL_W-1:0] stall_valid;
    logic [CTRL_W-1:0] flush_valid;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              branch_ack;
    logic              trap_ack;
    logic [31:0]       stall_cnt;
    logic [31:0]       redirect_cnt;

    int n_total;
    int n_pass;

    pipe_hazard_ctrl #(
        .XLEN   (XLEN),
        .CTRL_W (CTRL_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .load_use_req_i   (load_use_req),
        .if_busy_i        (if_busy),
        .ex_busy_i        (ex_busy),
        .mem_busy_i       (mem_busy),
        .branch_req_i     (branch_req),
        .branch_pc_i      (branch_pc),
        .trap_req_i       (trap_req),
        .trap_pc_i        (trap_pc),
        .perf_clr_i       (perf_clr),
        .stall_valid_o    (stall_valid),
        .flush_valid_o    (flush_valid),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .branch_ack_o     (branch_ack),
        .trap_ack_o       (trap_ack),
        .stall_cnt_o      (stall_cnt),
        .redirect_cnt_o   (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Check the control vectors, redirect and acks of the current cycle.
    task automatic check_ctrl(input string tag, input logic [5:0] st, input logic [5:0] fl,
                              input logic rv, input logic [63:0] rpc,
                              input logic ba, input logic ta);
        check_eq({tag, ".stall"}, 64'(stall_valid), 64'(st));
        check_eq({tag, ".flush"}, 64'(flush_valid), 64'(fl));
        check_eq({tag, ".redir"}, 64'(redirect_valid), 64'(rv));
        check_eq({tag, ".rpc"}, redirect_pc, rpc);
        check_eq({tag, ".back"}, 64'(branch_ack), 64'(ba));
        check_eq({tag, ".tack"}, 64'(trap_ack), 64'(ta));
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs;
        load_use_req = 1'b0;
        if_busy      = 1'b0;
        ex_busy      = 1'b0;
        mem_busy     = 1'b0;
        branch_req   = 1'b0;
        trap_req     = 1'b0;
        perf_clr     = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;

        // Reset with every request high: all outputs forced low.
        rst          = 1'b0;
        load_use_req = 1'b1;
        if_busy      = 1'b1;
        ex_busy      = 1'b1;
        mem_busy     = 1'b1;
        branch_req   = 1'b1;
        trap_req     = 1'b1;
        perf_clr     = 1'b0;
        branch_pc    = 64'h8000_0100;
        trap_pc      = 64'h8000_0004;
        next_cyc();
        next_cyc();
        sample();
        check_ctrl("rst", 6'h00, 6'h00, 1'b0, 64'h0, 1'b0, 1'b0);
        check_eq("rst.scnt", 64'(stall_cnt), 64'h0);
        check_eq("rst.rcnt", 64'(redirect_cnt), 64'h0);

        // Release with requests low.
        next_cyc();
        clear_reqs();
        rst = 1'b1;
        sample();
        check_ctrl("idle", 6'h00, 6'h00, 1'b0, 64'h0, 1'b0, 1'b0);

        // Load-use for one cycle.
        next_cyc();
        load_use_req = 1'b1;
        sample();
        check_ctrl("lu", 6'h03, 6'h04, 1'b0, 64'h0, 1'b0, 1'b0);
        next_cyc();
        load_use_req = 1'b0;
        sample();
        check_ctrl("lu_after", 6'h00, 6'h00, 1'b0, 64'h0, 1'b0, 1'b0);

        // ex_busy holds off a pending branch for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            ex_busy    = 1'b1;
            branch_req = 1'b1;
            branch_pc  = 64'h8000_0100;
            sample();
            check_ctrl($sformatf("exb%0d", i), 6'h07, 6'h08, 1'b0, 64'h0, 1'b0, 1'b0);
        end
        next_cyc();
        ex_busy = 1'b0;
        sample();
        check_ctrl("br", 6'h00, 6'h06, 1'b1, 64'h8000_0100, 1'b1, 1'b0);
        next_cyc();
        branch_req = 1'b0;

        // Trap with mem_busy high in the ack cycle and the first DRAIN cycle.
        trap_req = 1'b1;
        trap_pc  = 64'h8000_0004;
        mem_busy = 1'b1;
        sample();
        check_ctrl("trap_ack", 6'h01, 6'h1E, 1'b0, 64'h0, 1'b0, 1'b1);
        next_cyc();
        trap_pc = 64'hDEAD_BEEF_0000_0000;
        sample();
        check_ctrl("drain0", 6'h01, 6'h1E, 1'b0, 64'h0, 1'b0, 1'b0);
        next_cyc();
        mem_busy = 1'b0;
        sample();
        check_ctrl("drain1", 6'h01, 6'h1E, 1'b0, 64'h0, 1'b0, 1'b0);
        next_cyc();
        trap_req = 1'b0;
        sample();
        check_ctrl("tredir", 6'h00, 6'h1E, 1'b1, 64'h8000_0004, 1'b0, 1'b0);
        next_cyc();
        sample();
        check_ctrl("post_trap", 6'h00, 6'h00, 1'b0, 64'h0, 1'b0, 1'b0);

        // Trap and branch together: trap wins, redirect to trap PC next cycle.
        next_cyc();
        trap_req   = 1'b1;
        trap_pc    = 64'h8000_0200;
        branch_req = 1'b1;
        branch_pc  = 64'h8000_0300;
        sample();
        check_ctrl("tb_ack", 6'h01, 6'h1E, 1'b0, 64'h0, 1'b0, 1'b1);
        next_cyc();
        trap_req   = 1'b0;
        branch_req = 1'b0;
        sample();
        check_ctrl("tb_redir", 6'h00, 6'h1E, 1'b1, 64'h8000_0200, 1'b0, 1'b0);

        // Priority corners.
        next_cyc();
        mem_busy = 1'b1;
        ex_busy  = 1'b1;
        branch_req = 1'b1;
        sample();
        check_ctrl("memb", 6'h0F, 6'h10, 1'b0, 64'h0, 1'b0, 1'b0);
        next_cyc();
        clear_reqs();
        if_busy = 1'b1;
        sample();
        check_ctrl("ifb", 6'h01, 6'h02, 1'b0, 64'h0, 1'b0, 1'b0);
        next_cyc();
        branch_req   = 1'b1;
        branch_pc    = 64'h0000_0000_0000_1234;
        load_use_req = 1'b1;
        sample();
        check_ctrl("br_over", 6'h00, 6'h06, 1'b1, 64'h1234, 1'b1, 1'b0);

        // Reset during DRAIN aborts the trap.
        next_cyc();
        clear_reqs();
        trap_req = 1'b1;
        trap_pc  = 64'h8000_0400;
        mem_busy = 1'b1;
        sample();
        check_ctrl("ab_ack", 6'h01, 6'h1E, 1'b0, 64'h0, 1'b0, 1'b1);
        next_cyc();
        trap_req = 1'b0;
        sample();
        check_ctrl("ab_drain", 6'h01, 6'h1E, 1'b0, 64'h0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        check_ctrl("ab_rst", 6'h00, 6'h00, 1'b0, 64'h0, 1'b0, 1'b0);
        next_cyc();
        mem_busy = 1'b0;
        rst      = 1'b1;
        sample();
        check_ctrl("ab_rel0", 6'h00, 6'h00, 1'b0, 64'h0, 1'b0, 1'b0);
        next_cyc();
        sample();
        check_ctrl("ab_rel1", 6'h00, 6'h00, 1'b0, 64'h0, 1'b0, 1'b0);

        // Perf counters: 5 stall cycles and 2 redirects after a clear.
        next_cyc();
        perf_clr = 1'b1;
        next_cyc();
        perf_clr = 1'b0;
        if_busy  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_cyc();
        end
        next_cyc();
        if_busy    = 1'b0;
        branch_req = 1'b1;
        branch_pc  = 64'h8000_0800;
        next_cyc();
        next_cyc();
        branch_req = 1'b0;
        sample();
        check_eq("cnt.stall", 64'(stall_cnt), 64'(ExpStallCnt));
        check_eq("cnt.redir", 64'(redirect_cnt), 64'(ExpRedirCnt));
        next_cyc();
        perf_clr = 1'b1;
        if_busy  = 1'b1;
        next_cyc();
        perf_clr = 1'b0;
        if_busy  = 1'b0;
        sample();
        check_eq("clr.stall", 64'(stall_cnt), 64'h0);
        check_eq("clr.redir", 64'(redirect_cnt), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline control unit for the 5-stage core. It converts hazard, busy, branch and trap requests into the per-stage `stall_valid`/`flush_valid` vectors consumed by every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb). It also drives the PC redirect, and runs a small trap-sequencing FSM that drains an in-flight data-bus transaction before vectoring.

## Interface
- `XLEN`, 64, datapath/PC width.
- `CTRL_W`, 6, width of stall/flush vectors. Bit 0 = pc, 1 = if_id, 2 = id_ex, 3 = ex_mem, 4 = mem_wb, 5 = wb (reserved, always 0).

- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-low reset.
- `load_use_req_i`  in  1  ID detects a load-use hazard against EX.
- `if_busy_i`  in  1  fetch has not returned an instruction this cycle.
- `ex_busy_i`  in  1  multi-cycle EX op (mul/div) not finished.
- `mem_busy_i`  in  1  non-abortable data-bus transaction outstanding.
- `branch_req_i`  in  1  EX resolved a mispredicted branch/jump; held until `branch_ack_o`.
- `branch_pc_i`  in  XLEN  branch target.
- `trap_req_i`  in  1  MEM-stage trap/interrupt/mret; held until `trap_ack_o`.
- `trap_pc_i`  in  XLEN  trap vector / mepc target.
- `perf_clr_i`  in  1  synchronous clear of perf counters.
- `stall_valid_o`  out  CTRL_W  per-stage hold.
- `flush_valid_o`  out  CTRL_W  per-stage bubble insert.
- `redirect_valid_o`  out  1  PC stage loads `redirect_pc_o` this edge.
- `redirect_pc_o`  out  XLEN  redirect target.
- `branch_ack_o`  out  1  branch request accepted this cycle.
- `trap_ack_o`  out  1  trap request accepted this cycle.
- `stall_cnt_o`  out  32  cycles with `stall_valid_o[0]`=1.
- `redirect_cnt_o`  out  32  number of redirects issued.

## Operation
- FSM states are IDLE, DRAIN and REDIR. The state register and the latched `trap_pc_q` are the only control state. Stall/flush/redirect/ack outputs are combinational from state and inputs.
- IDLE, `trap_req_i`=1 (highest priority):
  - Assert `trap_ack_o`. Latch `trap_pc_q`.
  - Stall bit 0. Flush bits 4:1.
  - Next state is DRAIN if `mem_busy_i`, else REDIR.
- IDLE, no trap. Evaluate in priority order and apply only the first match:
  - `mem_busy_i`: stall 3:0, flush 4.
  - `ex_busy_i`: stall 2:0, flush 3. `branch_req_i` is not accepted.
  - `branch_req_i`: `branch_ack_o`=1, `redirect_valid_o`=1, `redirect_pc_o`=`branch_pc_i`, flush 2:1. This overrides `load_use_req_i` and `if_busy_i`.
  - `load_use_req_i`: stall 1:0, flush 2.
  - `if_busy_i`: stall 0, flush 1.
  - None: both vectors 0.
- DRAIN: stall bit 0, flush 4:1, all requests ignored. Leave for REDIR in the cycle `mem_busy_i`=0.
- REDIR (exactly 1 cycle): `redirect_valid_o`=1, `redirect_pc_o`=`trap_pc_q`, flush 4:1, then IDLE.
- Whenever no redirect is issued, `redirect_pc_o`=0.
- Bit 5 of both vectors is always 0.
- A requester whose request is not acked keeps it asserted. The block never queues requests.

## Timing
- Reset (`rst`=0, asynchronous): state goes to IDLE and `trap_pc_q` to 0. While in reset, every output is forced to 0, including both counters.
- Reset asserted mid-DRAIN or mid-REDIR aborts the trap. No redirect is issued after release.
- Stall/flush act with zero latency: values asserted in cycle N are sampled by the pipeline registers at the end of cycle N.
- Trap latency: `trap_ack_o` fires in cycle N. The redirect follows at N+1 when `mem_busy_i` was low at N. Otherwise it follows at M+1, where M is the first DRAIN cycle with `mem_busy_i`=0.
- Branch redirect latency is 0 cycles from acceptance.
- Trap and branch in the same IDLE cycle: the trap wins, and the branch is never acked (its instruction is flushed).
- Counters wrap at 2^32. `perf_clr_i` has priority over increment.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: `stall_cnt_o` increments on each cycle with `stall_valid_o[0]`=1. `redirect_cnt_o` increments on each cycle with `redirect_valid_o`=1.
- `PIPE_CTRL_PERF_EN` undefined: no counter flops are built, both outputs are tied to 0, and `perf_clr_i` is ignored. The ports remain.

## Test plan
- Reset: hold `rst`=0 with all requests high → all outputs 0. Release with requests low → `stall_valid_o`=`flush_valid_o`=6'h00.
- Load-use, 1 cycle → `stall_valid_o`=6'h03, `flush_valid_o`=6'h04. The next cycle returns to 0.
- `ex_busy_i` for 3 cycles with `branch_req_i` held, `branch_pc_i`=64'h8000_0100:
  - Busy cycles: `stall_valid_o`=6'h07, `flush_valid_o`=6'h08, no ack.
  - 4th cycle: `branch_ack_o`=1, `redirect_valid_o`=1, `redirect_pc_o`=64'h8000_0100, `flush_valid_o`=6'h06.
- Trap with `mem_busy_i` high 2 cycles, `trap_pc_i`=64'h8000_0004:
  - Ack cycle plus DRAIN cycles: `stall_valid_o`=6'h01, `flush_valid_o`=6'h1E.
  - REDIR cycle: redirect to 64'h8000_0004.
  - `trap_req_i` re-asserted during DRAIN is not acked.
- Simultaneous trap and branch in IDLE → `trap_ack_o`=1, `branch_ack_o`=0. The redirect target is the trap PC.
- With `PIPE_CTRL_PERF_EN`:
  - 5 stall cycles plus 2 redirects → `stall_cnt_o`=5, `redirect_cnt_o`=2.
  - `perf_clr_i` → both 0 the next cycle.
  - Preloading `stall_cnt_o` to 32'hFFFF_FFFF and stalling wraps it to 0.
